id_ex_stage_reg: RTL

- ID/EX pipeline register of the 5-stage pipelined CPU, directly downstream of the register file.
- Captures the register file's two read-data words and the decoded ID-stage fields each cycle and presents them to EX.
- Contains load-use hazard detection, generating the stall to PC/IF-ID and inserting bubbles into EX.
- Supports external hold (memory wait) and branch/jump flush; keeps saturating stall/bubble performance counters.

---
 rtl/id_ex_stage_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection
//
// Purpose:
//   Registers the register-file read data and the decoded ID-stage fields
//   into EX once per cycle. It also detects load-use hazards, turns hazard
//   and flush cycles into bubbles, and keeps saturating stall and bubble
//   counters.
//
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   hold                             freeze every register, including the counters
//   flush                            replace the instruction entering EX with a bubble
//   id_*                             ID-stage instruction fields and operand data
//   ex_*                             registered fields presented to EX
//   load_use_stall                   combinational stall request to PC and IF/ID
//   stall_count, bubble_count        saturating performance counters
module id_ex_stage_reg #(
  parameter int CTRL_W       = 12,
  parameter int REGWRITE_BIT = 0,
  parameter int MEMREAD_BIT  = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc_plus4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_read_data1,
  input  logic [31:0]       id_read_data2,
  input  logic [31:0]       id_imm_ext,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_pc_plus4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_read_data1,
  output logic [31:0]       ex_read_data2,
  output logic [31:0]       ex_imm_ext,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Both control-bit indices must fall inside the bundle.
  if (REGWRITE_BIT >= CTRL_W || MEMREAD_BIT >= CTRL_W) begin : g_bad_ctrl_index
    $error("control bit index outside control bundle");
  end

  logic rs_hit;
  logic rt_hit;
  logic bubble;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time. $0 is excluded because it is never really written.
  assign rs_hit = id_uses_rs & (id_rs == ex_rt);
  assign rt_hit = id_uses_rt & (id_rt == ex_rt);
  assign load_use_stall = ex_valid & ex_ctrl[MEMREAD_BIT] & id_valid &
                          (ex_rt != 5'd0) & (rs_hit | rt_hit);

  // Flush takes priority over the stall. Both insert the same bubble, and only
  // a stall that is not also flushed counts as a stall cycle.
  assign bubble = flush | load_use_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm_ext    <= '0;
      ex_ctrl       <= '0;
    end else if (!hold) begin
      if (bubble) begin
        // A cleared ex_ctrl also drops MemRead, so a stall never lasts more than one cycle.
        ex_valid      <= 1'b0;
        ex_pc_plus4   <= '0;
        ex_rs         <= '0;
        ex_rt         <= '0;
        ex_rd         <= '0;
        ex_read_data1 <= '0;
        ex_read_data2 <= '0;
        ex_imm_ext    <= '0;
        ex_ctrl       <= '0;
      end else begin
        ex_valid      <= id_valid;
        ex_pc_plus4   <= id_pc_plus4;
        ex_rs         <= id_rs;
        ex_rt         <= id_rt;
        ex_rd         <= id_rd;
        ex_read_data1 <= id_read_data1;
        ex_read_data2 <= id_read_data2;
        ex_imm_ext    <= id_imm_ext;
        // Masking the control bits keeps RegWrite and MemRead low for a non-instruction.
        ex_ctrl       <= id_valid ? id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else if (!hold) begin
      if (bubble && bubble_count != CNT_MAX) begin
        bubble_count <= bubble_count + CNT_ONE;
      end
      if (!flush && load_use_stall && stall_count != CNT_MAX) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

endmodule
